// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a local Fibonacci LFSR to the
// incoming bit stream, then flywheels on its own predictions to count bit errors.
module lfsr_checker #(
  parameter int WIDTH       = 5,
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] taps,
  input  logic             clear_errors,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] state_out
);

  localparam int FILL_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             pred;
  logic             count_en;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    pred        = ^(taps & state_q);
    fsm_d       = fsm_q;
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    count_en    = 1'b0;

    if (in_valid) begin
      case (fsm_q)
        SEED: begin
          state_d = {state_q[WIDTH-2:0], in_bit};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            fill_d = '0;
            // An all-zero register is a dead LFSR state; keep filling instead.
            if (state_d != '0) begin
              fsm_d   = HUNT;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        HUNT: begin
          state_d = {state_q[WIDTH-2:0], in_bit};
          if (in_bit == pred) begin
            if (match_q == 8'(LOCK_THRESH - 1)) begin
              fsm_d   = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          // Flywheel: the register follows its own prediction, not the line.
          state_d = {state_q[WIDTH-2:0], pred};
          if (in_bit == pred) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            count_en    = 1'b1;
            if (miss_q == 8'(LOSS_THRESH - 1)) begin
              fsm_d   = SEED;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end

        default: fsm_d = SEED;
      endcase
    end

    // Clear first, then count, so a clear coinciding with an error leaves 1.
    err_count_d = clear_errors ? '0 : err_count_q;
    if (count_en && (err_count_d != '1)) begin
      err_count_d = err_count_d + 1'b1;
    end

    locked_d = (fsm_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= SEED;
      state_q     <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: vector table, directed corner-case
// sequences and randomized traffic checked against a behavioural model.
module tb_lfsr_checker;

  localparam int W    = 5;
  localparam int LOCK = 8;
  localparam int LOSS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic [W-1:0] taps = 5'b10100;
  logic         clear_errors = 1'b0;

  logic         locked, err_pulse, locked4, err_pulse4;
  logic [15:0]  err_count;
  logic [3:0]   err_count4;
  logic [W-1:0] state_out, state_out4;

  lfsr_checker #(.WIDTH(W), .LOCK_THRESH(LOCK), .LOSS_THRESH(LOSS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .taps(taps),
    .clear_errors(clear_errors), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .state_out(state_out)
  );

  lfsr_checker #(.WIDTH(W), .LOCK_THRESH(LOCK), .LOSS_THRESH(LOSS), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .taps(taps),
    .clear_errors(clear_errors), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .state_out(state_out4)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_SEED, M_HUNT, M_LOCKED} mode_e;
  mode_e m_mode;
  bit    hist [W];       // hist[0] is the most recently stored bit
  int    m_fill, m_match, m_miss, m_cnt, m_cnt4;
  bit    m_pulse;

  function automatic logic [W-1:0] m_state();
    logic [W-1:0] s;
    for (int i = 0; i < W; i++) s[i] = hist[i];
    return s;
  endfunction

  task automatic model_reset();
    m_mode = M_SEED;
    for (int i = 0; i < W; i++) hist[i] = 1'b0;
    m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_cnt4 = 0; m_pulse = 1'b0;
  endtask

  task automatic model_push(input bit x);
    for (int i = W - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    int ones;
    bit p;
    m_pulse = 1'b0;
    if (clr) begin m_cnt = 0; m_cnt4 = 0; end
    if (!v) return;
    ones = 0;
    for (int i = 0; i < W; i++) if (taps[i] && hist[i]) ones++;
    p = bit'(ones % 2);
    case (m_mode)
      M_SEED: begin
        model_push(b);
        m_fill++;
        if (m_fill == W) begin
          m_fill = 0;
          if (m_state() != 0) begin m_mode = M_HUNT; m_match = 0; end
        end
      end
      M_HUNT: begin
        model_push(b);
        if (b == p) begin
          m_match++;
          if (m_match == LOCK) begin m_mode = M_LOCKED; m_match = 0; m_miss = 0; end
        end else m_match = 0;
      end
      default: begin
        model_push(p);
        if (b == p) m_miss = 0;
        else begin
          m_pulse = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
          m_miss++;
          if (m_miss == LOSS) begin m_mode = M_SEED; m_fill = 0; m_match = 0; m_miss = 0; end
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] gen;

  task automatic gen_next(output bit b);
    b = ^(taps & gen);
    gen = {gen[W-2:0], b};
  endtask

  task automatic step(input bit v, input bit b, input bit clr);
    in_valid = v; in_bit = b; clear_errors = clr;
    model_step(v, b, clr);
    @(posedge clk); #1;
    check("locked", locked, m_mode == M_LOCKED);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_cnt);
    check("state_out", state_out, m_state());
    check("err_count4", err_count4, m_cnt4);
  endtask

  task automatic send(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) begin gen_next(b); b ^= flip; end
    else b = bit'($urandom_range(0, 1));
    step(v, b, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);
    check("rst_state", state_out, 0);
    check("rst_count4", err_count4, 0);
    model_reset();
    gen = 5'b00001;
    in_valid = 1'b0; clear_errors = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit           v;
    bit           b;
    logic [W-1:0] exp_state;
    bit           exp_locked;
  } vec_t;

  vec_t vecs [7];
  int   lock_at, pulses, cyc, burst;
  bit   dropped;

  initial begin
    vecs[0] = '{1, 1, 5'b00001, 0};
    vecs[1] = '{1, 0, 5'b00010, 0};
    vecs[2] = '{0, 1, 5'b00010, 0};
    vecs[3] = '{1, 1, 5'b00101, 0};
    vecs[4] = '{1, 1, 5'b01011, 0};
    vecs[5] = '{1, 0, 5'b10110, 0};
    vecs[6] = '{1, 1, 5'b01101, 0}; // HUNT mispredict (pred=0), still shifted in

    model_reset();
    do_reset();

    // Vector table from reset.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].v, vecs[i].b, 1'b0);
      check("vec_state", state_out, vecs[i].exp_state);
      check("vec_locked", locked, vecs[i].exp_locked);
    end

    // Clean 1000-bit stream: lock after exactly 13 bits, no errors.
    do_reset();
    lock_at = -1; pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked && lock_at < 0) lock_at = i + 1;
      if (err_pulse) pulses++;
    end
    check("clean_lock_lat", lock_at, 13);
    check("clean_locked", locked, 1);
    check("clean_count", err_count, 0);
    check("clean_pulses", pulses, 0);

    // Single inverted bit at index 40: one pulse, flywheel keeps lock.
    do_reset();
    pulses = 0; dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, i == 40, 1'b0);
      if (i == 40) check("flip40_pulse", err_pulse, 1);
      if (i == 41) check("flip40_pulse_gone", err_pulse, 0);
      if (err_pulse) pulses++;
      if (i >= 12 && !locked) dropped = 1'b1;
    end
    check("flip40_pulses", pulses, 1);
    check("flip40_count", err_count, 1);
    check("flip40_dropped", dropped, 0);

    // Four consecutive errors drop lock on the 4th; relock 13 bits later.
    do_reset();
    for (int i = 0; i < 50; i++) send(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, 1'b0);
      if (i == 2) check("loss_3rd_locked", locked, 1);
    end
    check("loss_4th_locked", locked, 0);
    check("loss_count", err_count, 4);
    lock_at = -1;
    for (int i = 0; i < 40; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked && lock_at < 0) lock_at = i + 1;
    end
    check("relock_lat", lock_at, 13);

    // All-zero stream never leaves SEED.
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);
    check("zeros_locked", locked, 0);
    check("zeros_state", state_out, 0);
    check("zeros_count", err_count, 0);

    // in_valid toggling: 13th valid bit lands on cycle 26.
    do_reset();
    lock_at = -1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      send(cyc % 2 == 0, 1'b0, 1'b0);
      if (locked && lock_at < 0) lock_at = cyc;
    end
    check("toggle_lock_cycle", lock_at, 26);

    // Saturation with the 4-bit counter, clear+error, async reset.
    do_reset();
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      send(1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0);
    end
    check("sat_count4", err_count4, 15);
    check("sat_count16", err_count, 16);
    check("sat_locked", locked, 1);
    send(1'b1, 1'b1, 1'b1);
    check("clr_err_count", err_count, 1);
    check("clr_err_count4", err_count4, 1);
    check("clr_locked", locked, 1);
    do_reset();

    // Randomized traffic against the model, including a taps change.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      bit v, flip, clr;
      if (i == 2000) taps = 5'b10010;
      if (i == 3000) begin do_reset(); taps = 5'b10010; end
      v = ($urandom_range(0, 3) != 0);
      flip = 1'b0;
      if (burst > 0) begin
        flip = 1'b1;
        if (v) burst--;
      end else if ($urandom_range(0, 49) == 0) begin
        flip = 1'b1;
        if ($urandom_range(0, 2) == 0) burst = 3 + $urandom_range(0, 1);
      end
      clr = v && ($urandom_range(0, 99) == 0);
      send(v, flip, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
